hp0_wr_dma: RTL and testbench

//  Stream-to-DDR write DMA on the PS7 S_AXI_HP0 slave port (AXI3, 32-bit).

---
 rtl/hp0_wr_dma_pkg.sv | 25 ++
 rtl/hp0_wr_dma_if.sv | 51 +++++
 rtl/hp0_sync_fifo.sv | 67 ++++++
 rtl/hp0_wr_dma.sv | 197 +++++++++++++++++++
 tb/tb_hp0_wr_dma.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hp0_wr_dma_pkg.sv
// Shared AXI3 encodings, burst geometry and FSM state type
// for the HP0 stream-to-DDR write DMA.
package hp0_dma_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [2:0] SIZE_4B    = 3'b010;

  localparam int          BURST_BEATS = 16;
  localparam logic [31:0] BURST_BYTES = 32'd64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } hp0_wr_state_t;

  function automatic logic [31:0] align64(
    input logic [31:0] a
  );
    return {a[31:6], 6'b0};
  endfunction

endpackage

// File: rtl/hp0_wr_dma_if.sv
// AXI3 write-channel bundle of the PS7 S_AXI_HP0 slave port.
// master = DMA side, slave = PS / memory side.
interface hp0_wr_dma_if;

  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic [1:0]  awlock;
  logic [3:0]  awqos;
  logic [5:0]  awid;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic [5:0]  wid;
  logic        wvalid;
  logic        wready;

  logic        bvalid;
  logic [1:0]  bresp;
  logic [5:0]  bid;
  logic        bready;

  modport master (
    output awaddr, awlen, awsize, awburst,
    output awcache, awprot, awlock, awqos,
    output awid, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wid, wvalid,
    input  wready,
    input  bvalid, bresp, bid,
    output bready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst,
    input  awcache, awprot, awlock, awqos,
    input  awid, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wid, wvalid,
    output wready,
    output bvalid, bresp, bid,
    input  bready
  );

endinterface

// File: rtl/hp0_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count
// and a synchronous flush.
module hp0_sync_fifo #(
  parameter int W  = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic [AW:0]   count_o
);

  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

  logic [W-1:0]  mem_q [2**AW];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_en;
  logic          pop_en;

  assign full_o  = (cnt_q == DEPTH);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & (cnt_q != '0);

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_q] <= din_i;
  end

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_en) wr_d = wr_q + 1'b1;
    if (pop_en)  rd_d = rd_q + 1'b1;
    unique case ({push_en, pop_en})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hp0_wr_dma.sv
// Stream-to-DDR ring-buffer write DMA on S_AXI_HP0 (16-beat bursts).
// Define HP0_WR_DROP_EN to drop words at full instead of stalling.
module hp0_wr_dma
  import hp0_dma_pkg::*;
#(
  parameter int FIFO_AW = 5,
  parameter int AXI_ID  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_enable_i,
  input  logic [31:0] cfg_base_i,
  input  logic [31:0] cfg_size_i,
  input  logic [31:0] in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  hp0_wr_dma_if.master S_AXI_HP0,
  output logic [31:0] wr_ptr_o,
  output logic [31:0] burst_cnt_o,
`ifdef HP0_WR_DROP_EN
  output logic        err_o,
  output logic [31:0] drop_cnt_o
`else
  output logic        err_o
`endif
);

  localparam logic [FIFO_AW:0] BEATS_C =
    (FIFO_AW+1)'(BURST_BEATS);

  hp0_wr_state_t state_q, state_d;

  logic [31:0] awaddr_q, awaddr_d;
  logic [3:0]  beat_q, beat_d;
  logic [31:0] wr_ptr_q, wr_ptr_d;
  logic [31:0] burst_cnt_q, burst_cnt_d;
  logic        err_q, err_d;
  logic        pend_q, pend_d;
  logic [31:0] base_q, base_d;
  logic [31:0] size_q, size_d;
  logic [31:0] drop_q, drop_d;
  logic        en_q;
  logic        run_q;

  logic [31:0]        fifo_dout;
  logic               fifo_full;
  logic [FIFO_AW:0]   fifo_cnt;
  logic               push;
  logic               pop;
  logic               reload;
  logic [32:0]        ring_end;
  logic [32:0]        ptr_nxt;

  assign push = run_q & in_valid_i & ~fifo_full;
  assign pop  = (state_q == ST_DATA) & S_AXI_HP0.wready;

`ifdef HP0_WR_DROP_EN
  assign in_ready_o = run_q;
  assign drop_cnt_o = drop_q;
`else
  assign in_ready_o = run_q & ~fifo_full;
`endif

  hp0_sync_fifo #(
    .W  (32),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (reload),
    .push_i  (push),
    .din_i   (in_data_i),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .count_o (fifo_cnt)
  );

  assign ring_end = {1'b0, base_q} + {1'b0, size_q};
  assign ptr_nxt  = {1'b0, wr_ptr_q} + {1'b0, BURST_BYTES};

  always_comb begin
    state_d     = state_q;
    awaddr_d    = awaddr_q;
    beat_d      = beat_q;
    wr_ptr_d    = wr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    err_d       = err_q;
    base_d      = base_q;
    size_d      = size_q;
    drop_d      = drop_q;
    reload      = 1'b0;
    // a rising edge seen mid-burst is held until IDLE
    pend_d      = pend_q | (cfg_enable_i & ~en_q);
`ifdef HP0_WR_DROP_EN
    if (run_q && in_valid_i && fifo_full)
      drop_d = drop_q + 32'd1;
`endif
    unique case (state_q)
      ST_IDLE: begin
        base_d = align64(cfg_base_i);
        size_d = align64(cfg_size_i);
        if (pend_d) begin
          reload      = 1'b1;
          pend_d      = 1'b0;
          wr_ptr_d    = align64(cfg_base_i);
          burst_cnt_d = '0;
          err_d       = 1'b0;
          drop_d      = '0;
        end else if (cfg_enable_i && fifo_cnt >= BEATS_C) begin
          awaddr_d = wr_ptr_q;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (S_AXI_HP0.awready) begin
          beat_d  = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (S_AXI_HP0.wready) begin
          beat_d = beat_q + 4'd1;
          if (beat_q == 4'hF) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (S_AXI_HP0.bvalid) begin
          burst_cnt_d = burst_cnt_q + 32'd1;
          err_d = err_q | (S_AXI_HP0.bresp != RESP_OKAY);
          wr_ptr_d = (ptr_nxt >= ring_end) ?
                     base_q : ptr_nxt[31:0];
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      awaddr_q    <= '0;
      beat_q      <= '0;
      wr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      err_q       <= 1'b0;
      pend_q      <= 1'b0;
      base_q      <= '0;
      size_q      <= '0;
      drop_q      <= '0;
      en_q        <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      awaddr_q    <= awaddr_d;
      beat_q      <= beat_d;
      wr_ptr_q    <= wr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      err_q       <= err_d;
      pend_q      <= pend_d;
      base_q      <= base_d;
      size_q      <= size_d;
      drop_q      <= drop_d;
      en_q        <= cfg_enable_i;
      run_q       <= 1'b1;
    end
  end

  assign S_AXI_HP0.awaddr  = awaddr_q;
  assign S_AXI_HP0.awlen   = 4'hF;
  assign S_AXI_HP0.awsize  = SIZE_4B;
  assign S_AXI_HP0.awburst = BURST_INCR;
  assign S_AXI_HP0.awcache = 4'b0011;
  assign S_AXI_HP0.awprot  = 3'b000;
  assign S_AXI_HP0.awlock  = 2'b00;
  assign S_AXI_HP0.awqos   = 4'h0;
  assign S_AXI_HP0.awid    = AXI_ID[5:0];
  assign S_AXI_HP0.awvalid = (state_q == ST_ADDR);

  assign S_AXI_HP0.wdata   = fifo_dout;
  assign S_AXI_HP0.wstrb   = 4'hF;
  assign S_AXI_HP0.wid     = AXI_ID[5:0];
  assign S_AXI_HP0.wvalid  = (state_q == ST_DATA);
  assign S_AXI_HP0.wlast   = (state_q == ST_DATA) &&
                             (beat_q == 4'hF);
  assign S_AXI_HP0.bready  = (state_q == ST_RESP);

  assign wr_ptr_o    = wr_ptr_q;
  assign burst_cnt_o = burst_cnt_q;
  assign err_o       = err_q;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_HP0.bid, cfg_base_i[5:0],
                       cfg_size_i[5:0]};

endmodule

// File: tb/tb_hp0_wr_dma.sv
// Directed bench for hp0_wr_dma: scoreboard of AW addresses
// and W data, checked by immediate assertions.
module tb_hp0_wr_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_enable = 1'b0;
  logic [31:0] cfg_base = '0;
  logic [31:0] cfg_size = '0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] wr_ptr;
  logic [31:0] burst_cnt;
  logic        err;
`ifdef HP0_WR_DROP_EN
  logic [31:0] drop_cnt;
`endif

  hp0_wr_dma_if axi ();

  hp0_wr_dma dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_enable_i (cfg_enable),
    .cfg_base_i   (cfg_base),
    .cfg_size_i   (cfg_size),
    .in_data_i    (in_data),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .S_AXI_HP0    (axi),
    .wr_ptr_o     (wr_ptr),
    .burst_cnt_o  (burst_cnt),
`ifdef HP0_WR_DROP_EN
    .err_o        (err),
    .drop_cnt_o   (drop_cnt)
`else
    .err_o        (err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_aw[$];
  logic [31:0] exp_w[$];

  int aw_delay = 0;
  int aw_wait  = 0;
  int w_mode   = 0;
  int aw_cnt   = 0;
  int b_cnt    = 0;
  int err_at   = -1;
  int w_beat   = 0;
  bit aw_done  = 1'b0;
  bit b_pend   = 1'b0;
  bit b_fired  = 1'b0;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] AWF  =
    {4'h0, 4'hF, 3'b010, 2'b01, 4'b0011,
     3'b000, 2'b00, 4'h0, 6'h00};

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  initial begin
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'b00;
    axi.bid     = 6'h0;
  end

  // AXI slave model and scoreboard consumer
  always @(negedge clk) begin
    if (!rst) begin
      if (b_fired) begin
        axi.bvalid = 1'b0;
        axi.bresp  = 2'b00;
        b_fired    = 1'b0;
      end
      if (b_pend) begin
        axi.bvalid = 1'b1;
        axi.bresp  = (b_cnt + 1 == err_at) ? 2'b10 : 2'b00;
        b_pend     = 1'b0;
      end
      if (axi.awvalid) begin
        axi.awready = (aw_wait >= aw_delay);
        aw_wait++;
      end else begin
        axi.awready = 1'b0;
        aw_wait     = 0;
      end
      case (w_mode)
        0:       axi.wready = 1'b1;
        1:       axi.wready = 1'($urandom_range(0, 1));
        default: axi.wready = 1'b0;
      endcase
      if (axi.awvalid && axi.awready) begin
        if (exp_aw.size() == 0)
          chk("aw_unexpected", axi.awaddr, 32'hFFFF_FFFF);
        else
          chk("awaddr", axi.awaddr, exp_aw.pop_front());
        chk("aw_fields",
            {4'h0, axi.awlen, axi.awsize, axi.awburst,
             axi.awcache, axi.awprot, axi.awlock,
             axi.awqos, axi.awid}, AWF);
        aw_done = 1'b1;
        aw_cnt++;
        aw_wait = 0;
      end
      if (axi.wvalid)
        chk("w_before_aw", 32'(aw_done), 32'd1);
      if (axi.wvalid && axi.wready) begin
        if (exp_w.size() == 0)
          chk("w_unexpected", axi.wdata, 32'hFFFF_FFFF);
        else
          chk("wdata", axi.wdata, exp_w.pop_front());
        chk("wlast", 32'(axi.wlast), 32'(w_beat == 15));
        chk("w_fields", {22'h0, axi.wid, axi.wstrb},
            32'h0000_000F);
        w_beat++;
        if (axi.wlast) begin
          aw_done = 1'b0;
          b_pend  = 1'b1;
          w_beat  = 0;
        end
      end
      if (axi.bvalid && axi.bready) begin
        b_fired = 1'b1;
        b_cnt++;
      end
    end
  end

  task automatic push(input int n,
                      input logic [31:0] start,
                      input int keep);
    for (int i = 0; i < n; i++) begin
      int t;
      in_valid = 1'b1;
      in_data  = start + 32'(i);
      t = 0;
      while (!in_ready && t < 2000) begin
        @(negedge clk);
        t++;
      end
      chk("in_ready_wait", 32'(in_ready), 32'd1);
      if (i < keep) exp_w.push_back(start + 32'(i));
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_b(input int target);
    int t;
    t = 0;
    while (b_cnt < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("b_count", 32'(b_cnt), 32'(target));
    @(negedge clk);
  endtask

  task automatic reenable(input logic [31:0] base,
                          input logic [31:0] size);
    @(negedge clk);
    cfg_enable = 1'b0;
    cfg_base   = base;
    cfg_size   = size;
    @(negedge clk);
    cfg_enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int b0;
    int a0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_ptr", wr_ptr, 32'd0);
    chk("rst_burst_cnt", burst_cnt, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_axi_valid",
        {29'h0, axi.awvalid, axi.wvalid, axi.bready},
        32'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic single burst
    reenable(BASE, 32'h100);
    chk("en_wr_ptr", wr_ptr, BASE);
    exp_aw.push_back(BASE);
    push(16, 32'd0, 16);
    wait_b(1);
    chk("basic_wr_ptr", wr_ptr, BASE + 32'h40);
    chk("basic_burst_cnt", burst_cnt, 32'd1);
    chk("basic_err", 32'(err), 32'd0);

    // ring wrap with a 128-byte ring
    reenable(BASE, 32'h80);
    exp_aw.push_back(BASE);
    exp_aw.push_back(BASE + 32'h40);
    exp_aw.push_back(BASE);
    push(48, 32'd100, 48);
    wait_b(4);
    chk("wrap_wr_ptr", wr_ptr, BASE + 32'h40);
    chk("wrap_burst_cnt", burst_cnt, 32'd3);

    // backpressure: late awready, stalled then random wready
    reenable(BASE, 32'h100);
    aw_delay = 5;
    w_mode   = 2;
    exp_aw.push_back(BASE);
    exp_aw.push_back(BASE + 32'h40);
    push(32, 32'd200, 32);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    w_mode = 1;
    wait_b(6);
    chk("bp_wr_ptr", wr_ptr, BASE + 32'h80);
    chk("bp_burst_cnt", burst_cnt, 32'd2);
    aw_delay = 0;
    w_mode   = 0;

    // SLVERR on the second burst
    reenable(BASE, 32'h100);
    err_at = b_cnt + 2;
    b0 = b_cnt;
    repeat (3) exp_aw.push_back(32'h0);
    exp_aw[0] = BASE;
    exp_aw[1] = BASE + 32'h40;
    exp_aw[2] = BASE + 32'h80;
    push(48, 32'd300, 48);
    wait_b(b0 + 1);
    chk("err_b1", 32'(err), 32'd0);
    wait_b(b0 + 2);
    chk("err_b2", 32'(err), 32'd1);
    wait_b(b0 + 3);
    chk("err_b3", 32'(err), 32'd1);
    chk("err_wr_ptr", wr_ptr, BASE + 32'hC0);
    reenable(BASE, 32'h100);
    chk("err_cleared", 32'(err), 32'd0);
    chk("err_cnt_cleared", burst_cnt, 32'd0);
    chk("err_ptr_reload", wr_ptr, BASE);

    // disable after beat 5 of a burst
    b0 = b_cnt;
    exp_aw.push_back(BASE);
    push(16, 32'd400, 16);
    for (int t = 0; t < 200 && w_beat < 6; t++)
      @(negedge clk);
    cfg_enable = 1'b0;
    wait_b(b0 + 1);
    chk("dis_wr_ptr", wr_ptr, BASE + 32'h40);
    chk("dis_burst_cnt", burst_cnt, 32'd1);
    a0 = aw_cnt;
    push(16, 32'd500, 16);
    repeat (20) begin
      @(negedge clk);
      chk("dis_no_aw", 32'(axi.awvalid), 32'd0);
    end
    chk("dis_aw_cnt", 32'(aw_cnt), 32'(a0));
    exp_w.delete();
    reenable(BASE, 32'h100);
    chk("reen_wr_ptr", wr_ptr, BASE);
    chk("reen_burst_cnt", burst_cnt, 32'd0);
    b0 = b_cnt;
    exp_aw.push_back(BASE);
    push(16, 32'd600, 16);
    wait_b(b0 + 1);
    chk("reen_wr_ptr2", wr_ptr, BASE + 32'h40);

`ifdef HP0_WR_DROP_EN
    // overflow discards words instead of stalling
    reenable(BASE, 32'h100);
    w_mode = 2;
    b0 = b_cnt;
    exp_aw.push_back(BASE);
    exp_aw.push_back(BASE + 32'h40);
    push(40, 32'd700, 32);
    chk("drop_in_ready", 32'(in_ready), 32'd1);
    chk("drop_cnt", drop_cnt, 32'd8);
    w_mode = 0;
    wait_b(b0 + 2);
    chk("drop_wr_ptr", wr_ptr, BASE + 32'h80);
    reenable(BASE, 32'h100);
    chk("drop_cnt_clr", drop_cnt, 32'd0);
`endif

    repeat (5) @(negedge clk);
    chk("aw_queue_left", 32'(exp_aw.size()), 32'd0);
    chk("w_queue_left", 32'(exp_w.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
